sim_exit_monitor: RTL and testbench

// - Simulation end-of-test monitor. Sits directly upstream of the top-level test driver and produces
//   the success/failure indication that the driver samples each core_clock edge to finish or fatal.
// - Consumes tohost-style 64-bit mailbox writes from the serial/TSI adapter and decodes exit requests.
// - Runs a progress watchdog fed by a core heartbeat, and reports an exit code plus a failure reason.

---
 rtl/sim_exit_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_sim_exit_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_monitor.sv
// -----------------------------------------------------------------------------
// sim_exit_monitor
//
// End-of-test monitor for simulation. It takes tohost-style 64-bit mailbox
// writes, decodes exit requests, runs a progress watchdog fed by a core
// heartbeat, and raises a sticky success/failure verdict with a reason code
// and the latched exit code. The test driver samples success/failure on
// every core_clock edge.
//
// Optional feature (macro SIM_EXIT_CONSOLE_EN):
//   When defined, writes tagged 8'h01/8'h01 in req_data[63:48] produce a
//   one-cycle character strobe on console_valid/console_char. When undefined,
//   those ports do not exist and such writes are acked and ignored.
//
// Ports:
//   core_clock     in   1   clock, all state updates on posedge
//   reset          in   1   synchronous, active-low
//   heartbeat      in   1   1-cycle progress pulse, restarts the watchdog
//   req_valid      in   1   mailbox write valid
//   req_ready      out  1   mailbox write ready (high only while running)
//   req_data       in   64  mailbox write payload
//   success        out  1   test passed, held until reset
//   failure        out  1   test failed, held until reset
//   reason         out  2   0 none, 1 nonzero exit code, 2 watchdog timeout
//   exit_code      out  31  req_data[31:1] of the accepted exit write
//   console_valid  out  1   (SIM_EXIT_CONSOLE_EN) 1-cycle character strobe
//   console_char   out  8   (SIM_EXIT_CONSOLE_EN) character
// -----------------------------------------------------------------------------
module sim_exit_monitor #(
  parameter int STARTUP_CYCLES = 8,
  parameter int DRAIN_CYCLES   = 16,
  parameter int WDOG_CYCLES    = 1000000,
  parameter int WDOG_W         = 32
) (
  input  logic        core_clock,
  input  logic        reset,
  input  logic        heartbeat,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  output logic        success,
  output logic        failure,
  output logic [1:0]  reason,
`ifdef SIM_EXIT_CONSOLE_EN
  output logic        console_valid,
  output logic [7:0]  console_char,
`endif
  output logic [30:0] exit_code
);

  // One counter serves startup, watchdog and drain since those phases never
  // overlap; size it for the largest of the three.
  localparam int ST_W  = $clog2(STARTUP_CYCLES + 1);
  localparam int DR_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int MAX_A = (ST_W > DR_W) ? ST_W : DR_W;
  localparam int CNT_W = (WDOG_W > MAX_A) ? WDOG_W : MAX_A;

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST    =
    CNT_W'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_STARTUP    = 3'd0,
    ST_RUN        = 3'd1,
    ST_DRAIN_PASS = 3'd2,
    ST_DRAIN_FAIL = 3'd3,
    ST_PASS       = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req_ready_reg, req_ready_next;
  logic              success_reg, success_next;
  logic              failure_reg, failure_next;
  logic [1:0]        reason_reg, reason_next;
  logic [30:0]       exit_code_reg, exit_code_next;

  // req_ready_reg is only high in RUN, so accept implies RUN.
  logic accept;
  logic is_exit;
  assign accept  = req_valid & req_ready_reg;
  assign is_exit = accept && (req_data[63:56] == 8'h00) && req_data[0];

  // Payload bits that carry no meaning for this block.
  logic unused_data;
  assign unused_data = ^req_data[55:32];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge core_clock) begin
    if (!reset) begin
      state_reg <= ST_STARTUP;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_STARTUP: begin
        if (cnt_reg == STARTUP_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        // Any accept or heartbeat counts as progress, which is also how an
        // exit write or heartbeat on the expiry cycle cancels the timeout.
        if (is_exit) begin
          state_next = (req_data[31:1] == 31'd0) ? ST_DRAIN_PASS : ST_DRAIN_FAIL;
          cnt_next   = '0;
        end else if (heartbeat || accept) begin
          cnt_next = '0;
        end else if (WDOG_CYCLES != 0) begin
          if (cnt_reg == WDOG_LAST) begin
            state_next = ST_FAIL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_DRAIN_PASS, ST_DRAIN_FAIL: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next = (state_reg == ST_DRAIN_PASS) ? ST_PASS : ST_FAIL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        // PASS / FAIL are terminal until reset.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the output registers, derived from the
  // upcoming state so every port comes straight from a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready_next = (state_next == ST_RUN);
    success_next   = (state_next == ST_PASS);
    failure_next   = (state_next == ST_FAIL);
    reason_next    = reason_reg;
    exit_code_next = exit_code_reg;
    if (state_reg == ST_RUN && state_next == ST_FAIL) begin
      reason_next = 2'd2;
    end else if (state_reg == ST_DRAIN_FAIL && state_next == ST_FAIL) begin
      reason_next = 2'd1;
    end
    if (is_exit) begin
      exit_code_next = req_data[31:1];
    end
  end

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      req_ready_reg <= 1'b0;
      success_reg   <= 1'b0;
      failure_reg   <= 1'b0;
      reason_reg    <= 2'd0;
      exit_code_reg <= 31'd0;
    end else begin
      req_ready_reg <= req_ready_next;
      success_reg   <= success_next;
      failure_reg   <= failure_next;
      reason_reg    <= reason_next;
      exit_code_reg <= exit_code_next;
    end
  end

  assign req_ready = req_ready_reg;
  assign success   = success_reg;
  assign failure   = failure_reg;
  assign reason    = reason_reg;
  assign exit_code = exit_code_reg;

`ifdef SIM_EXIT_CONSOLE_EN
  // Console character strobe: one cycle per accepted 8'h01/8'h01 write.
  logic       console_valid_reg, console_valid_next;
  logic [7:0] console_char_reg, console_char_next;

  always_comb begin
    console_valid_next = accept && (req_data[63:56] == 8'h01) &&
                         (req_data[55:48] == 8'h01);
    console_char_next  = console_valid_next ? req_data[7:0] : console_char_reg;
  end

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      console_valid_reg <= 1'b0;
      console_char_reg  <= 8'h00;
    end else begin
      console_valid_reg <= console_valid_next;
      console_char_reg  <= console_char_next;
    end
  end

  assign console_valid = console_valid_reg;
  assign console_char  = console_char_reg;
`endif

endmodule

// File: tb/tb_sim_exit_monitor.sv
// -----------------------------------------------------------------------------
// tb_sim_exit_monitor
//
// Directed self-checking bench for sim_exit_monitor with STARTUP_CYCLES=8,
// DRAIN_CYCLES=16, WDOG_CYCLES=100. Inputs are driven and outputs sampled on
// the falling edge; all expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_sim_exit_monitor;

  logic        core_clock = 1'b0;
  logic        reset      = 1'b0;
  logic        heartbeat  = 1'b0;
  logic        req_valid  = 1'b0;
  logic [63:0] req_data   = 64'd0;
  logic        req_ready;
  logic        success;
  logic        failure;
  logic [1:0]  reason;
  logic [30:0] exit_code;
`ifdef SIM_EXIT_CONSOLE_EN
  logic        console_valid;
  logic [7:0]  console_char;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  sim_exit_monitor #(
    .STARTUP_CYCLES(8),
    .DRAIN_CYCLES  (16),
    .WDOG_CYCLES   (100),
    .WDOG_W        (32)
  ) dut (
    .core_clock   (core_clock),
    .reset        (reset),
    .heartbeat    (heartbeat),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .success      (success),
    .failure      (failure),
    .reason       (reason),
`ifdef SIM_EXIT_CONSOLE_EN
    .console_valid(console_valid),
    .console_char (console_char),
`endif
    .exit_code    (exit_code)
  );

  always #5 core_clock = ~core_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reset for 2 cycles, release, and wait until the first RUN cycle
  // (watchdog count 0, req_ready high).
  task automatic start_run();
    @(negedge core_clock);
    reset     = 1'b0;
    heartbeat = 1'b0;
    req_valid = 1'b0;
    req_data  = 64'd0;
    repeat (2) @(negedge core_clock);
    reset = 1'b1;
    repeat (8) @(negedge core_clock);
    check("run_ready", req_ready, 1);
  endtask

  initial begin
    logic bad;

    // ---- Startup window with req_valid held high, then pass exit ----------
    @(negedge core_clock);
    reset     = 1'b0;
    req_valid = 1'b1;
    req_data  = 64'h1;
    repeat (3) @(negedge core_clock);
    check("rst_ready", req_ready, 0);
    check("rst_success", success, 0);
    check("rst_failure", failure, 0);
    check("rst_reason", reason, 0);
    check("rst_exit_code", exit_code, 0);
`ifdef SIM_EXIT_CONSOLE_EN
    check("rst_console_valid", console_valid, 0);
    check("rst_console_char", console_char, 0);
`endif
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("startup_ready_c%0d", i), req_ready, 0);
      @(negedge core_clock);
    end
    check("startup_ready_c9", req_ready, 1);
    @(negedge core_clock);          // exit write 64'h1 accepted
    req_valid = 1'b0;
    check("drain_ready", req_ready, 0);
    repeat (15) @(negedge core_clock);
    check("pass_before_drain_end", success, 0);
    @(negedge core_clock);
    check("pass_success", success, 1);
    check("pass_failure", failure, 0);
    check("pass_reason", reason, 0);
    check("pass_exit_code", exit_code, 0);
    // Terminal hold: traffic and heartbeats must not disturb the verdict.
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      heartbeat = i[0];
      req_valid = 1'b1;
      req_data  = 64'h7;
      @(negedge core_clock);
      if (success !== 1'b1 || failure !== 1'b0 || reason !== 2'd0 ||
          exit_code !== 31'd0 || req_ready !== 1'b0)
        bad = 1'b1;
    end
    heartbeat = 1'b0;
    req_valid = 1'b0;
    check("pass_hold_1000", bad, 0);

    // ---- Nonzero exit code -------------------------------------------------
    start_run();
    req_valid = 1'b1;
    req_data  = 64'h7;
    @(negedge core_clock);
    req_valid = 1'b0;
    repeat (15) @(negedge core_clock);
    check("fail_before_drain_end", failure, 0);
    @(negedge core_clock);
    check("fail_failure", failure, 1);
    check("fail_reason", reason, 1);
    check("fail_exit_code", exit_code, 3);
    check("fail_success", success, 0);

    // ---- Watchdog timeout with no activity ---------------------------------
    start_run();
    repeat (99) @(negedge core_clock);
    check("wdog_c100_failure", failure, 0);
    @(negedge core_clock);
    check("wdog_c101_failure", failure, 1);
    check("wdog_c101_reason", reason, 2);
    check("wdog_c101_success", success, 0);
    check("wdog_c101_ready", req_ready, 0);

    // ---- Heartbeat every 50 cycles keeps the run alive ---------------------
    start_run();
    bad = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      heartbeat = ((i % 50) == 49);
      @(negedge core_clock);
      if (failure !== 1'b0) bad = 1'b1;
    end
    heartbeat = 1'b0;
    check("hb_no_failure", bad, 0);
    check("hb_still_ready", req_ready, 1);

    // ---- Non-exit writes count as progress and do not exit -----------------
    start_run();
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      req_valid = ((i % 60) == 59);
      req_data  = ((i % 120) == 59) ? 64'h0300_0000_0000_0001 : 64'h0000_0000_0000_0006;
      @(negedge core_clock);
      if (failure !== 1'b0 || success !== 1'b0) bad = 1'b1;
    end
    req_valid = 1'b0;
    check("nonexit_no_verdict", bad, 0);
    check("nonexit_ready", req_ready, 1);
    check("nonexit_exit_code", exit_code, 0);

    // ---- Exit write on the watchdog-expiry cycle wins ----------------------
    start_run();
    repeat (99) @(negedge core_clock);
    req_valid = 1'b1;
    req_data  = 64'h1;
    @(negedge core_clock);
    req_valid = 1'b0;
    check("race_exit_failure", failure, 0);
    check("race_exit_ready", req_ready, 0);
    repeat (15) @(negedge core_clock);
    check("race_exit_pre_success", success, 0);
    @(negedge core_clock);
    check("race_exit_success", success, 1);
    check("race_exit_reason", reason, 0);
    check("race_exit_failure_end", failure, 0);

    // ---- Heartbeat on the expiry cycle cancels it --------------------------
    start_run();
    repeat (99) @(negedge core_clock);
    heartbeat = 1'b1;
    @(negedge core_clock);
    heartbeat = 1'b0;
    check("race_hb_c101_failure", failure, 0);
    repeat (99) @(negedge core_clock);
    check("race_hb_c200_failure", failure, 0);
    @(negedge core_clock);
    check("race_hb_c201_failure", failure, 1);
    check("race_hb_c201_reason", reason, 2);

    // ---- Reset pulsed mid-drain aborts the verdict -------------------------
    start_run();
    req_valid = 1'b1;
    req_data  = 64'h7;
    @(negedge core_clock);
    req_valid = 1'b0;
    check("middrain_exit_code", exit_code, 3);
    repeat (5) @(negedge core_clock);
    reset = 1'b0;
    @(negedge core_clock);
    reset = 1'b1;
    check("middrain_rst_exit_code", exit_code, 0);
    check("middrain_rst_failure", failure, 0);
    check("middrain_rst_ready", req_ready, 0);
    bad = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (req_ready !== 1'b0) bad = 1'b1;
      @(negedge core_clock);
    end
    check("middrain_restart_window", bad, 0);
    check("middrain_restart_ready", req_ready, 1);
    repeat (20) @(negedge core_clock);
    check("middrain_no_success", success, 0);
    check("middrain_no_failure", failure, 0);

    // ---- Console-tagged write ----------------------------------------------
    start_run();
    req_valid = 1'b1;
    req_data  = 64'h0101_0000_0000_0041;
    @(negedge core_clock);
    req_valid = 1'b0;
`ifdef SIM_EXIT_CONSOLE_EN
    check("console_valid", console_valid, 1);
    check("console_char", console_char, 8'h41);
`endif
    check("console_ready", req_ready, 1);
    check("console_exit_code", exit_code, 0);
    @(negedge core_clock);
`ifdef SIM_EXIT_CONSOLE_EN
    check("console_valid_drop", console_valid, 0);
`endif
    check("console_success", success, 0);
    check("console_failure", failure, 0);
    check("console_still_run", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
